// File: rtl/ring_ro_sequencer_if.sv
// ---------------------------------------------------------------------------
// ring_ro_sequencer_if
// Bundles every non-clock/reset signal of ring_ro_sequencer.
//   master : the environment side (trigger logic, ADC front end, FIFO status)
//   slave  : the sequencer itself
// Signals:
//   sample_valid_i, trig_i, offset_i, howmany_i, post_trig_i, fifo_full_i
//                                   -> inputs to the sequencer
//   wr_en_o, wr_addr_o, rd_en_o, rd_addr_o, data_valid_o, busy_o, done_o
//                                   -> outputs of the sequencer
// Optional (macro TRIG_DROP_CNT_EN): drop_clr_i in, drop_cnt_o[15:0] out.
// ---------------------------------------------------------------------------
interface ring_ro_sequencer_if #(
    parameter int SIZE = 8,
    parameter int PTW  = 8
);
    logic            sample_valid_i;
    logic            trig_i;
    logic [SIZE-1:0] offset_i;
    logic [SIZE-1:0] howmany_i;
    logic [PTW-1:0]  post_trig_i;
    logic            fifo_full_i;

    logic            wr_en_o;
    logic [SIZE-1:0] wr_addr_o;
    logic            rd_en_o;
    logic [SIZE-1:0] rd_addr_o;
    logic            data_valid_o;
    logic            busy_o;
    logic            done_o;

`ifdef TRIG_DROP_CNT_EN
    logic            drop_clr_i;
    logic [15:0]     drop_cnt_o;
`endif

    modport master (
`ifdef TRIG_DROP_CNT_EN
        output drop_clr_i,
        input  drop_cnt_o,
`endif
        output sample_valid_i, trig_i, offset_i, howmany_i, post_trig_i, fifo_full_i,
        input  wr_en_o, wr_addr_o, rd_en_o, rd_addr_o, data_valid_o, busy_o, done_o
    );

    modport slave (
`ifdef TRIG_DROP_CNT_EN
        input  drop_clr_i,
        output drop_cnt_o,
`endif
        input  sample_valid_i, trig_i, offset_i, howmany_i, post_trig_i, fifo_full_i,
        output wr_en_o, wr_addr_o, rd_en_o, rd_addr_o, data_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/ring_ro_sequencer.sv
// ---------------------------------------------------------------------------
// ring_ro_sequencer
// Ring-buffer controller for the digitizer. Owns the write pointer, keeps
// writing until a trigger plus post_trig samples, freezes, then reads back
// `howmany` samples starting `offset` behind the freeze point while obeying
// the downstream FIFO full flag.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ring_ro_sequencer_if.slave (trigger/config in, RAM strobes out,
//          busy/done status out)
// Optional feature macro: TRIG_DROP_CNT_EN adds a saturating 16-bit count of
// triggers seen while busy (bus.drop_cnt_o), cleared at done when
// bus.drop_clr_i is high.
// ---------------------------------------------------------------------------
module ring_ro_sequencer #(
    parameter int SIZE = 8,
    parameter int PTW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ring_ro_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        POST,
        LATCH,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [SIZE-1:0] wr_addr;
    logic [SIZE-1:0] rd_ptr, rd_ptr_next;
    logic [SIZE-1:0] remcnt, remcnt_next;
    logic [SIZE-1:0] offset_r, offset_next;
    logic [SIZE-1:0] howmany_r, howmany_next;
    logic [PTW-1:0]  ptcnt, ptcnt_next;
    logic            data_valid;
    logic            wr_en;
    logic            issue;

    // Gated by rst_n so the write strobe reads 0 while reset is held, even
    // though the state already sits in IDLE.
    assign wr_en = rst_n && bus.sample_valid_i && (state == IDLE || state == POST);
    assign issue = (state == READ) && !bus.fifo_full_i;

    assign bus.wr_en_o      = wr_en;
    assign bus.wr_addr_o    = wr_addr;
    assign bus.rd_en_o      = issue;
    assign bus.rd_addr_o    = issue ? rd_ptr : '0;
    assign bus.data_valid_o = data_valid;
    assign bus.busy_o       = (state != IDLE);
    assign bus.done_o       = (state == DONE);

    // NOTE: every register, including the captured configuration, is cleared
    // by reset so a mid-burst abort leaves no stale pointer or count behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_addr    <= '0;
            rd_ptr     <= '0;
            remcnt     <= '0;
            offset_r   <= '0;
            howmany_r  <= '0;
            ptcnt      <= '0;
            data_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values regardless of statement order.
            state      <= state_next;
            rd_ptr     <= rd_ptr_next;
            remcnt     <= remcnt_next;
            offset_r   <= offset_next;
            howmany_r  <= howmany_next;
            ptcnt      <= ptcnt_next;
            data_valid <= issue;
            if (wr_en) begin
                wr_addr <= wr_addr + SIZE'(1);
            end
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first so no path through the case leaves
        // a signal unassigned (which would infer a latch).
        state_next   = state;
        rd_ptr_next  = rd_ptr;
        remcnt_next  = remcnt;
        offset_next  = offset_r;
        howmany_next = howmany_r;
        ptcnt_next   = ptcnt;

        unique case (state)
            IDLE: begin
                if (bus.trig_i) begin
                    offset_next  = bus.offset_i;
                    howmany_next = bus.howmany_i;
                    ptcnt_next   = bus.post_trig_i;
                    // A sample coinciding with the trigger is pre-trigger data;
                    // the countdown starts with the next written sample.
                    state_next   = (bus.post_trig_i == '0) ? LATCH : POST;
                end
            end
            POST: begin
                if (bus.sample_valid_i) begin
                    ptcnt_next = ptcnt - PTW'(1);
                    if (ptcnt == PTW'(1)) begin
                        state_next = LATCH;
                    end
                end
            end
            LATCH: begin
                // wr_addr is frozen here and points at the next free slot.
                rd_ptr_next = wr_addr - offset_r;
                remcnt_next = howmany_r;
                state_next  = (howmany_r == '0) ? DONE : READ;
            end
            READ: begin
                if (!bus.fifo_full_i) begin
                    rd_ptr_next = rd_ptr + SIZE'(1);
                    remcnt_next = remcnt - SIZE'(1);
                    if (remcnt == SIZE'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef TRIG_DROP_CNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (state == DONE && bus.drop_clr_i) begin
            drop_cnt <= '0;
        end else if (bus.trig_i && state != IDLE && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign bus.drop_cnt_o = drop_cnt;
`endif

endmodule

// File: tb/tb_ring_ro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ring_ro_sequencer
// Self-checking bench for ring_ro_sequencer. Directed bursts (basic, wrap,
// back-pressure, degenerate, reset mid-read, retrigger) followed by random
// bursts. Expected values come from the burst's timeline: write pointer
// advances per accepted sample, freeze point, read addresses
// freeze - offset + k, and the fixed latch/drain/done cycles.
// Build with +define+TRIG_DROP_CNT_EN to also check the drop counter.
// ---------------------------------------------------------------------------
module tb_ring_ro_sequencer;
    localparam int SIZE = 8;
    localparam int PTW  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ring_ro_sequencer_if #(.SIZE(SIZE), .PTW(PTW)) bus ();

    ring_ro_sequencer #(.SIZE(SIZE), .PTW(PTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic drop_clr = 1'b0;
`ifdef TRIG_DROP_CNT_EN
    assign bus.drop_clr_i = drop_clr;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference state
    logic [SIZE-1:0] model_wr = '0;
    logic            pend_wr  = 1'b0;
    int              exp_drop = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rnd(input int pct);
        return ($urandom_range(99, 0) < pct);
    endfunction

    // Set inputs, then move to the falling edge where outputs are checked.
    task automatic drive(input logic sv, input logic tr, input logic full);
        bus.sample_valid_i = sv;
        bus.trig_i         = tr;
        bus.fifo_full_i    = full;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        if (pend_wr) model_wr = model_wr + SIZE'(1);
        pend_wr = 1'b0;
        #1;
    endtask

    task automatic check_write(input logic exp_en);
        check("wr_en", bus.wr_en_o, exp_en);
        check("wr_addr", bus.wr_addr_o, model_wr);
        pend_wr = exp_en;
    endtask

    task automatic check_drop();
`ifdef TRIG_DROP_CNT_EN
        check("drop_cnt", bus.drop_cnt_o, exp_drop);
`endif
    endtask

    // Model update for the edge closing the current cycle.
    task automatic note_drop(input logic busy, input logic tr, input logic clr_now);
        if (clr_now) exp_drop = 0;
        else if (busy && tr && exp_drop < 65535) exp_drop++;
    endtask

    task automatic idle_cycle(input logic sv);
        drive(sv, 1'b0, 1'b0);
        check("idle_busy", bus.busy_o, 0);
        check("idle_done", bus.done_o, 0);
        check("idle_rd_en", bus.rd_en_o, 0);
        check("idle_dvalid", bus.data_valid_o, 0);
        check_write(sv);
        advance();
    endtask

    task automatic idle_until(input logic [SIZE-1:0] target);
        int guard = 0;
        while (model_wr != target && guard < 600) begin
            idle_cycle(1'b1);
            guard++;
        end
        if (model_wr != target) check("idle_until_timeout", model_wr, target);
    endtask

    // One complete trigger-to-done sequence.
    // full_mode: 0 never full, 1 random full, 2 three-cycle stall after two reads
    task automatic run_burst(input int post, input int off, input int hm,
                             input int full_mode, input int sv_pct,
                             input int retrig_n, input int exp_freeze);
        logic [SIZE-1:0] freeze, exp_addr;
        int   left, issued, guard, pulses, stall_left;
        logic sv, tr, full, prev_issue, clr;

        // Trigger cycle (sample here is pre-trigger)
        bus.offset_i    = SIZE'(off);
        bus.howmany_i   = SIZE'(hm);
        bus.post_trig_i = PTW'(post);
        sv = rnd(sv_pct);
        drive(sv, 1'b1, 1'b0);
        check("trig_busy", bus.busy_o, 0);
        check_write(sv);
        advance();

        // Later config changes must not matter.
        bus.offset_i    = SIZE'($urandom);
        bus.howmany_i   = SIZE'($urandom);
        bus.post_trig_i = PTW'($urandom);

        pulses = 0;
        left   = post;
        guard  = 0;
        while (left > 0 && guard < 1000) begin
            sv = rnd(sv_pct);
            tr = (pulses < retrig_n);
            if (tr) pulses++;
            drive(sv, tr, 1'($urandom_range(1, 0)));
            check("post_busy", bus.busy_o, 1);
            check("post_rd_en", bus.rd_en_o, 0);
            check("post_done", bus.done_o, 0);
            check_write(sv);
            check_drop();
            note_drop(1'b1, tr, 1'b0);
            if (sv) left--;
            advance();
            guard++;
        end
        if (left != 0) check("post_timeout", left, 0);

        // Latch cycle: writes frozen, no read yet
        freeze = model_wr;
        tr = (pulses < retrig_n);
        if (tr) pulses++;
        drive(rnd(sv_pct), tr, 1'b0);
        check_write(1'b0);
        if (exp_freeze >= 0) check("freeze_addr", bus.wr_addr_o, exp_freeze);
        check("latch_rd_en", bus.rd_en_o, 0);
        check("latch_rd_addr", bus.rd_addr_o, 0);
        check("latch_busy", bus.busy_o, 1);
        check("latch_done", bus.done_o, 0);
        check_drop();
        note_drop(1'b1, tr, 1'b0);
        advance();

        // Read burst
        issued     = 0;
        prev_issue = 1'b0;
        stall_left = 3;
        guard      = 0;
        while (issued < hm && guard < 2000) begin
            case (full_mode)
                1:       full = rnd(30);
                2:       full = (issued == 2 && stall_left > 0);
                default: full = 1'b0;
            endcase
            if (full && full_mode == 2) stall_left--;
            tr = (pulses < retrig_n);
            if (tr) pulses++;
            drive(rnd(sv_pct), tr, full);
            exp_addr = freeze - SIZE'(off) + SIZE'(issued);
            check("rd_en", bus.rd_en_o, !full);
            check("rd_addr", bus.rd_addr_o, full ? '0 : exp_addr);
            check("rd_dvalid", bus.data_valid_o, prev_issue);
            check("rd_busy", bus.busy_o, 1);
            check("rd_done", bus.done_o, 0);
            check_write(1'b0);
            check_drop();
            note_drop(1'b1, tr, 1'b0);
            prev_issue = !full;
            if (!full) issued++;
            advance();
            guard++;
        end
        if (issued != hm) check("read_timeout", issued, hm);

        // Drain cycle carries the final data_valid
        if (hm > 0) begin
            tr = rnd(30);
            drive(rnd(sv_pct), tr, 1'($urandom_range(1, 0)));
            check("drain_rd_en", bus.rd_en_o, 0);
            check("drain_dvalid", bus.data_valid_o, 1);
            check("drain_done", bus.done_o, 0);
            check("drain_busy", bus.busy_o, 1);
            check_write(1'b0);
            check_drop();
            note_drop(1'b1, tr, 1'b0);
            advance();
        end

        // Done cycle; a trigger here is dropped
        clr      = rnd(50);
        drop_clr = clr;
        tr       = rnd(50);
        drive(rnd(sv_pct), tr, 1'($urandom_range(1, 0)));
        check("done_pulse", bus.done_o, 1);
        check("done_busy", bus.busy_o, 1);
        check("done_rd_en", bus.rd_en_o, 0);
        check("done_dvalid", bus.data_valid_o, 0);
        check_write(1'b0);
        check_drop();
        note_drop(1'b1, tr, clr);
        advance();
        drop_clr = 1'b0;

        // Back in IDLE: single-cycle done, writing resumes
        sv = rnd(sv_pct);
        drive(sv, 1'b0, 1'b0);
        check("after_busy", bus.busy_o, 0);
        check("after_done", bus.done_o, 0);
        check_write(sv);
        check_drop();
        advance();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, bus.wr_en_o, 0);
        check({tag, "_wr_addr"}, bus.wr_addr_o, 0);
        check({tag, "_rd_en"}, bus.rd_en_o, 0);
        check({tag, "_rd_addr"}, bus.rd_addr_o, 0);
        check({tag, "_dvalid"}, bus.data_valid_o, 0);
        check({tag, "_busy"}, bus.busy_o, 0);
        check({tag, "_done"}, bus.done_o, 0);
`ifdef TRIG_DROP_CNT_EN
        check({tag, "_drop"}, bus.drop_cnt_o, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.sample_valid_i = 1'b1;
        bus.trig_i         = 1'b0;
        bus.offset_i       = '0;
        bus.howmany_i      = '0;
        bus.post_trig_i    = '0;
        bus.fifo_full_i    = 1'b0;

        // Reset state (sample_valid held high to show wr_en is suppressed)
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // 1: basic burst, trigger at wr_addr 0x40, freeze at 0x45, reads 3B..40
        idle_until(8'h40);
        run_burst(4, 10, 6, 0, 100, 0, 8'h45);

        // 2: wrap-around, freeze at 0x03, reads FB..02
        idle_until(8'h00);
        run_burst(2, 8, 8, 0, 100, 0, 8'h03);

        // 3: back-pressure stall mid-burst
        idle_cycle(1'b1);
        run_burst(3, 5, 8, 2, 100, 0, -1);

        // 4: degenerate IDLE->LATCH->DONE
        idle_cycle(1'b0);
        run_burst(0, 17, 0, 0, 100, 0, -1);

        // 5: reset mid-READ
        bus.offset_i    = 8'd4;
        bus.howmany_i   = 8'd20;
        bus.post_trig_i = 8'd1;
        drive(1'b1, 1'b1, 1'b0); advance();   // trigger
        drive(1'b1, 1'b0, 1'b0); advance();   // post
        drive(1'b1, 1'b0, 1'b0); advance();   // latch
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            check("pre_reset_rd_en", bus.rd_en_o, 1);
            advance();
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #3;
        rst_n    = 1'b1;
        pend_wr  = 1'b0;
        model_wr = '0;
        exp_drop = 0;
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // 6: three retriggers while busy; readout unaffected
        run_burst(4, 6, 6, 1, 100, 3, -1);

        // Random bursts
        for (int b = 0; b < 25; b++) begin
            int gap = $urandom_range(5, 0);
            for (int g = 0; g < gap; g++) idle_cycle(rnd(60));
            run_burst($urandom_range(12, 0), $urandom_range(255, 0), $urandom_range(40, 0),
                      $urandom_range(1, 0), $urandom_range(100, 50), $urandom_range(3, 0), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
